// File: rtl/mem_port_arbiter_if.sv
// Memory command/response bus between the port arbiter (master) and the memory model (slave).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_valid,
        output m_we,
        output m_addr,
        output m_wdata,
        input  m_ready,
        input  m_rvalid,
        input  m_rdata
    );

    modport slave (
        input  m_valid,
        input  m_we,
        input  m_addr,
        input  m_wdata,
        output m_ready,
        output m_rvalid,
        output m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store, one transaction
// at a time, with data priority, a fetch starvation guard and a per-transaction timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [DATA_W-1:0]  i_rdata,
    output logic               i_done,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_done,
    output logic               err,
    mem_port_arbiter_if.master mem,
    output logic               busy,
    output logic               gnt_d
);
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [TW-1:0] TmoLast   = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] StarveMax = SW'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e        state;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] starve_cnt;
    logic          data_win;
    logic          fetch_win;
    logic          fin_ok;
    logic          fin_tmo;

    always_comb begin
        data_win  = d_req && !(i_req && (starve_cnt == StarveMax));
        fetch_win = i_req && !data_win;
        fin_ok    = ((state == StIssue) && mem.m_ready && mem.m_we) ||
                    ((state == StWait) && mem.m_rvalid);
        // An accepted read on the last cycle cannot complete in time, so it aborts too.
        fin_tmo   = ((state == StIssue) || (state == StWait)) && (tmo_cnt == TmoLast) && !fin_ok;
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            tmo_cnt     <= '0;
            starve_cnt  <= '0;
            gnt_d       <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            err         <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem.m_valid <= 1'b0;
            mem.m_we    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (data_win || fetch_win) begin
                        state       <= StIssue;
                        gnt_d       <= data_win;
                        tmo_cnt     <= '0;
                        mem.m_valid <= 1'b1;
                        mem.m_we    <= data_win && d_we;
                        mem.m_addr  <= data_win ? d_addr : i_addr;
                        mem.m_wdata <= data_win ? d_wdata : '0;
                        if (fetch_win || !i_req) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != StarveMax) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (mem.m_ready && !mem.m_we) begin
                        mem.m_valid <= 1'b0;
                        state       <= StWait;
                    end
                end
                StWait: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
                StResp: begin
                    state <= StIdle;
                end
            endcase

            // Entry into RESP overrides the per-state next state above.
            if (fin_ok || fin_tmo) begin
                state       <= StResp;
                mem.m_valid <= 1'b0;
                i_done      <= !gnt_d;
                d_done      <= gnt_d;
                err         <= fin_tmo;
                if (!mem.m_we) begin
                    if (gnt_d) begin
                        d_rdata <= fin_tmo ? '0 : mem.m_rdata;
                    end else begin
                        i_rdata <= fin_tmo ? '0 : mem.m_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        err;
    logic        busy;
    logic        gnt_d;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem ();

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (16),
        .STARVE_MAX(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .i_addr (i_addr),
        .i_rdata(i_rdata),
        .i_done (i_done),
        .d_req  (d_req),
        .d_we   (d_we),
        .d_addr (d_addr),
        .d_wdata(d_wdata),
        .d_rdata(d_rdata),
        .d_done (d_done),
        .err    (err),
        .mem    (mem),
        .busy   (busy),
        .gnt_d  (gnt_d)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read transaction with a one-cycle memory latency; starts in an IDLE cycle, ends in RESP.
    task automatic rd_txn(input logic exp_d, input logic [31:0] addr, input logic [31:0] val);
        step();
        chk("rd_valid", mem.m_valid, 1);
        chk("rd_gnt", gnt_d, exp_d);
        chk("rd_addr", mem.m_addr, addr);
        chk("rd_we", mem.m_we, 0);
        step();
        chk("rd_wait_valid", mem.m_valid, 0);
        mem.m_rvalid = 1'b1;
        mem.m_rdata  = val;
        step();
        mem.m_rvalid = 1'b0;
        mem.m_rdata  = 32'h0;
        chk("rd_idone", i_done, !exp_d);
        chk("rd_ddone", d_done, exp_d);
        chk("rd_err", err, 0);
        chk("rd_data", exp_d ? d_rdata : i_rdata, val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        mem.m_ready  = 1'b0;
        mem.m_rvalid = 1'b0;
        mem.m_rdata  = 32'h0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", mem.m_valid, 0);
        chk("rst_mwe", mem.m_we, 0);
        chk("rst_maddr", mem.m_addr, 0);
        chk("rst_done", {30'b0, i_done, d_done}, 0);
        chk("rst_err", err, 0);
        chk("rst_gnt", gnt_d, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);

        // Single fetch
        i_req = 1'b1;
        i_addr = 32'h40;
        mem.m_ready = 1'b1;
        rd_txn(1'b0, 32'h40, 32'h0050_0093);
        i_req = 1'b0;
        step();
        chk("f_idle", busy, 0);
        chk("f_done_clr", i_done, 0);
        chk("f_hold", i_rdata, 32'h0050_0093);

        // Store with two stall cycles
        d_req = 1'b1;
        d_we = 1'b1;
        d_addr = 32'h100;
        d_wdata = 32'hDEAD_BEEF;
        mem.m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("st_valid", mem.m_valid, 1);
            chk("st_we", mem.m_we, 1);
            chk("st_addr", mem.m_addr, 32'h100);
            chk("st_wdata", mem.m_wdata, 32'hDEAD_BEEF);
            chk("st_nodone", d_done, 0);
        end
        mem.m_ready = 1'b1;
        step();
        chk("st_done", d_done, 1);
        chk("st_err", err, 0);
        chk("st_mvalid", mem.m_valid, 0);
        chk("st_rdata", d_rdata, 0);
        d_req = 1'b0;
        d_we = 1'b0;
        step();
        chk("st_idle", busy, 0);

        // Starvation guard: four data grants, then fetch, then data again
        d_req = 1'b1;
        d_addr = 32'h200;
        i_req = 1'b1;
        i_addr = 32'h80;
        for (int k = 0; k < 4; k++) begin
            rd_txn(1'b1, 32'h200 + 32'(4 * k), 32'h1000 + 32'(k));
            d_addr = 32'h200 + 32'(4 * (k + 1));
            step();
        end
        rd_txn(1'b0, 32'h80, 32'h0000_F00D);
        chk("sv_starve_clr", 32'(dut.starve_cnt), 0);
        i_req = 1'b0;
        step();
        rd_txn(1'b1, 32'h210, 32'h1004);
        d_req = 1'b0;
        step();
        chk("sv_ihold", i_rdata, 32'h0000_F00D);

        // Timeout: read accepted, no response
        d_req = 1'b1;
        d_addr = 32'h300;
        step();
        chk("to_issue", mem.m_valid, 1);
        for (int c = 1; c < 16; c++) begin
            step();
            chk("to_nodone", d_done, 0);
        end
        step();
        chk("to_done", d_done, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 0);
        d_req = 1'b0;
        step();
        mem.m_rvalid = 1'b1;
        mem.m_rdata = 32'h0000_0BAD;
        step();
        mem.m_rvalid = 1'b0;
        chk("to_late", d_rdata, 0);
        chk("to_late_busy", busy, 0);

        // Reset in WAIT
        i_req = 1'b1;
        i_addr = 32'h44;
        step();
        step();
        chk("rw_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        i_req = 1'b0;
        chk("rw_idle", busy, 0);
        chk("rw_mvalid", mem.m_valid, 0);
        chk("rw_nodone", {30'b0, i_done, d_done}, 0);
        mem.m_rvalid = 1'b1;
        mem.m_rdata = 32'h0000_0BAD;
        step();
        mem.m_rvalid = 1'b0;
        chk("rw_stale", i_rdata, 0);
        chk("rw_stale_done", i_done, 0);
        i_req = 1'b1;
        i_addr = 32'h48;
        rd_txn(1'b0, 32'h48, 32'h0000_CAFE);
        i_req = 1'b0;
        step();

        // Completion on the last timeout cycle wins
        d_req = 1'b1;
        d_addr = 32'h400;
        step();
        for (int c = 1; c < 16; c++) begin
            step();
        end
        mem.m_rvalid = 1'b1;
        mem.m_rdata = 32'h1234_5678;
        step();
        mem.m_rvalid = 1'b0;
        chk("tie_done", d_done, 1);
        chk("tie_err", err, 0);
        chk("tie_rdata", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        step();
        chk("tie_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the multi-cycle CPU's single memory port between the instruction-fetch requester and the load/store requester. It replaces the IorD mux with a real arbiter. The arbiter serializes requests with a small FSM, gives data accesses fixed priority with a starvation guard for fetch, and bounds every transaction with a timeout. It sits between the control unit/datapath and the memory model. It accepts one outstanding transaction at a time.

## Interface
- ADDR_W, default 32, address width
- DATA_W, default 32, data width
- TIMEOUT, default 16, max cycles spent in ISSUE+WAIT before abort (≥2)
- STARVE_MAX, default 4, consecutive data grants allowed while fetch is pending
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request (level; held with i_addr until i_done)
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word; updated at i_done, held otherwise
- i_done  out  1  one-cycle completion pulse, fetch port
- d_req  in  1  data request (level; held with d_we/d_addr/d_wdata until d_done)
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; updated at d_done, held otherwise
- d_done  out  1  one-cycle completion pulse, data port
- err  out  1  high during a done pulse when that transaction timed out
- m_valid  out  1  memory command valid
- m_we  out  1  memory command is a write
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_ready  in  1  memory accepts command when m_valid && m_ready
- m_rvalid  in  1  read data valid; occurs ≥1 cycle after acceptance
- m_rdata  in  DATA_W  read data
- busy  out  1  state != IDLE
- gnt_d  out  1  current/last grant was data port (registered)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate combinationally on the current req levels.
  - Data wins, unless i_req && starve_cnt == STARVE_MAX, in which case fetch wins.
  - On a grant, latch we/addr/wdata (fetch: we=0) and gnt_d, clear the timeout counter, and go to ISSUE.
  - With no req, stay in IDLE.
- starve_cnt:
  - On a data grant with i_req high: +1, saturating at STARVE_MAX.
  - On a data grant with i_req low: reset to 0.
  - On any fetch grant: reset to 0.
- ISSUE: m_valid=1 and m_we/m_addr/m_wdata come from the latched registers.
  - Accepted write: go to RESP.
  - Accepted read: go to WAIT.
  - Not accepted: hold the command stable.
  - m_rvalid is ignored in this state.
- WAIT: m_valid=0. On m_rvalid, capture m_rdata into the granted port's rdata register and go to RESP.
- Timeout: the counter increments every cycle in ISSUE/WAIT. If it reaches TIMEOUT-1 without completion that cycle, go to RESP with an error flag, drop m_valid, and write 0 into the granted port's rdata (load/fetch only).
  - Completion takes precedence over timeout in the same cycle.
- RESP: pulse the granted port's done for exactly one cycle; err=err_flag. Then go to IDLE.
- Requester rule: drop req (or present a new request) by the edge after done.
  - A req still high in the following IDLE cycle is treated as a new request.
- m_rvalid outside WAIT (including a stale response after a timeout or reset) is ignored.

## Timing
- Reset values: state IDLE; m_valid, m_we, i_done, d_done, err, busy, gnt_d = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; starve_cnt = 0; timeout counter = 0.
- Reset mid-transaction: IDLE on the next edge, m_valid low the following cycle, and no done or err is emitted.
- Write, m_ready always high:
  - c0 IDLE grant
  - c1 ISSUE accept
  - c2 RESP done
  - Done arrives 2 cycles after req is first seen.
- Read, m_ready high, m_rvalid one cycle after accept:
  - c0 grant
  - c1 accept
  - c2 WAIT rvalid
  - c3 done, with rdata valid from c3
  - Each extra memory wait cycle adds 1.
- Back-to-back requests: new grant in the IDLE cycle after RESP. Minimum issue spacing is 3 cycles for writes and 4 for reads.
- Simultaneous i_req and d_req in IDLE: only one grant; the loser waits with its req held.

## Test plan
- Single fetch: i_req, i_addr=0x40; memory returns 0x00500093 one cycle after accept -> i_done at c3, i_rdata=0x00500093, err=0, d_done never asserted.
- Store: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, m_ready low 2 cycles -> m_valid held 3 cycles with stable fields, d_done one cycle after accept, err=0.
- Conflict/starvation: d_req held continuously with new loads, i_req held -> 4 data grants, then a fetch grant, starve_cnt=0, then data resumes.
- Timeout: read accepted, m_rvalid never asserted, TIMEOUT=16 -> done+err exactly 16 cycles after ISSUE entry, rdata=0; a late m_rvalid is ignored and does not alter rdata.
- Reset mid-WAIT: reset one cycle during WAIT -> next cycle IDLE, busy=0, no done pulse; a subsequent m_rvalid is ignored; the next request completes normally.
- Completion-vs-timeout tie: m_rvalid arrives on the TIMEOUT-1 cycle with 0x12345678 -> done with err=0, rdata=0x12345678.
